// File: rtl/swerv_types.sv
// -----------------------------------------------------------------------------
// swerv_types
//   Shared types for the execute-unit FPU controller.
//   - fpu_pkt_t       : decoded floating-point op handed over by decode
//   - fpu_ctl_state_t : sequencer states of exu_fpu_ctl
//   - rounding-mode constants and helpers used to resolve the dynamic mode
//     and to reject the reserved encodings
// -----------------------------------------------------------------------------
package swerv_types;

    // Decoded FP operation. valid qualifies the whole packet.
    typedef struct packed {
        logic       valid;
        logic [2:0] rnd_mode;
        logic [3:0] op;
        logic       op_mod;
    } fpu_pkt_t;

    // Sequencer states of the FPU issue/writeback controller.
    typedef enum logic [2:0] {
        FPU_IDLE  = 3'd0,
        FPU_REQ   = 3'd1,
        FPU_WAIT  = 3'd2,
        FPU_DRAIN = 3'd3,
        FPU_WB    = 3'd4
    } fpu_ctl_state_t;

    // Instruction rounding-mode field value meaning "use fcsr.frm".
    localparam logic [2:0] RND_DYN    = 3'b111;
    // Encodings that are reserved once the dynamic mode has been resolved.
    localparam logic [2:0] RND_RSVD_A = 3'b101;
    localparam logic [2:0] RND_RSVD_B = 3'b110;

    // Pick the effective rounding mode for an instruction.
    function automatic logic [2:0] resolve_rnd(input logic [2:0] rnd_mode,
                                               input logic [2:0] frm);
        return (rnd_mode == RND_DYN) ? frm : rnd_mode;
    endfunction

    // A resolved mode that cannot be executed.
    function automatic logic rnd_is_reserved(input logic [2:0] mode);
        return (mode == RND_RSVD_A) || (mode == RND_RSVD_B);
    endfunction

endpackage

// File: rtl/exu_fpu_ctl.sv
// -----------------------------------------------------------------------------
// exu_fpu_ctl
//   FPU issue/writeback sequencer between decode and a multi-cycle FPU core.
//   One operation is outstanding at a time: decode hands over an op, the
//   rounding mode is resolved, the op is issued on a valid/ready request
//   channel, the tagged response is captured and then held on the writeback
//   port until the register file accepts it. Flushes kill anything not yet
//   written back; an already issued request is drained by tag.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   dec_fpu_p                decoded op (valid, rnd_mode, op, op_mod)
//   dec_fpu_rd               destination register
//   dec_fpu_rs1/2/3_d        source operands
//   csr_frm                  dynamic rounding mode from fcsr
//   flush                    kill any op not yet written back
//   fpu_busy                 decode stall, high whenever not idle
//   fpu_illegal              one-cycle pulse: reserved rounding mode, op dropped
//   fpc_req_*/fpc_op...      request channel to the FPU core
//   fpc_rsp_*                response channel from the FPU core
//   fpu_wb_*                 writeback channel to the register file
// -----------------------------------------------------------------------------
import swerv_types::*;

module exu_fpu_ctl #(
    parameter int TAG_W = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  fpu_pkt_t          dec_fpu_p,
    input  logic [4:0]        dec_fpu_rd,
    input  logic [31:0]       dec_fpu_rs1_d,
    input  logic [31:0]       dec_fpu_rs2_d,
    input  logic [31:0]       dec_fpu_rs3_d,
    input  logic [2:0]        csr_frm,
    input  logic              flush,

    output logic              fpu_busy,
    output logic              fpu_illegal,

    output logic              fpc_req_valid,
    input  logic              fpc_req_ready,
    output logic [3:0]        fpc_op,
    output logic              fpc_op_mod,
    output logic [2:0]        fpc_rnd,
    output logic [95:0]       fpc_operands,
    output logic [TAG_W-1:0]  fpc_tag,

    input  logic              fpc_rsp_valid,
    output logic              fpc_rsp_ready,
    input  logic [TAG_W-1:0]  fpc_rsp_tag,
    input  logic [31:0]       fpc_rsp_result,
    input  logic [4:0]        fpc_rsp_status,

    output logic              fpu_wb_valid,
    input  logic              fpu_wb_ready,
    output logic [4:0]        fpu_wb_rd,
    output logic [31:0]       fpu_wb_data,
    output logic [4:0]        fpu_wb_fflags
);

    fpu_ctl_state_t    state_q;
    fpu_ctl_state_t    state_d;

    // Request payload, held stable from accept until the op retires.
    logic [3:0]        op_q;
    logic              op_mod_q;
    logic [2:0]        rnd_q;
    logic [95:0]       operands_q;
    logic [4:0]        rd_q;

    // tag_q is the tag the next request carries; issued_tag_q is the tag
    // of the request currently in flight inside the core.
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  issued_tag_q;

    // Writeback holding registers.
    logic [4:0]        wb_rd_q;
    logic [31:0]       wb_data_q;
    logic [4:0]        wb_fflags_q;

    logic              illegal_q;

    logic [2:0]        resolved_rnd;
    logic              dec_take;
    logic              dec_reserved;
    logic              dec_accept;
    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_match;
    logic              wb_capture;

    // Decode handshake: only an idle controller looks at decode, and a
    // flush in the same cycle kills the incoming op before it is taken.
    always_comb begin
        resolved_rnd = resolve_rnd(dec_fpu_p.rnd_mode, csr_frm);
        dec_reserved = rnd_is_reserved(resolved_rnd);
        dec_take     = (state_q == FPU_IDLE) && dec_fpu_p.valid && !flush;
        dec_accept   = dec_take && !dec_reserved;
    end

    // Channel events. The response is only consumed while fpc_rsp_ready
    // is high, so rsp_fire already implies WAIT or DRAIN.
    always_comb begin
        req_fire   = (state_q == FPU_REQ) && fpc_req_ready;
        rsp_fire   = fpc_rsp_valid && fpc_rsp_ready;
        rsp_match  = rsp_fire && (fpc_rsp_tag == issued_tag_q);
        wb_capture = (state_q == FPU_WAIT) && rsp_match && !flush;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FPU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. A flush together with a request
    // handshake means the core already owns the op, so its response must
    // still be drained. A flush together with the matching response in
    // WAIT retires the op on the spot.
    always_comb begin
        state_d       = state_q;
        fpc_req_valid = 1'b0;
        fpc_rsp_ready = 1'b0;
        fpu_wb_valid  = 1'b0;
        fpu_busy      = (state_q != FPU_IDLE);

        case (state_q)
            FPU_IDLE: begin
                if (dec_accept) begin
                    state_d = FPU_REQ;
                end
            end
            FPU_REQ: begin
                fpc_req_valid = 1'b1;
                if (fpc_req_ready) begin
                    state_d = flush ? FPU_DRAIN : FPU_WAIT;
                end else if (flush) begin
                    state_d = FPU_IDLE;
                end
            end
            FPU_WAIT: begin
                fpc_rsp_ready = 1'b1;
                if (flush) begin
                    state_d = rsp_match ? FPU_IDLE : FPU_DRAIN;
                end else if (rsp_match) begin
                    state_d = FPU_WB;
                end
            end
            FPU_DRAIN: begin
                fpc_rsp_ready = 1'b1;
                if (rsp_match) begin
                    state_d = FPU_IDLE;
                end
            end
            FPU_WB: begin
                fpu_wb_valid = 1'b1;
                if (flush || fpu_wb_ready) begin
                    state_d = FPU_IDLE;
                end
            end
            default: begin
                state_d = FPU_IDLE;
            end
        endcase
    end

    // Request payload capture on accept. Decode contents are ignored while
    // busy, so the payload stays put until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            op_mod_q   <= 1'b0;
            rnd_q      <= '0;
            operands_q <= '0;
            rd_q       <= '0;
        end else if (dec_accept) begin
            op_q       <= dec_fpu_p.op;
            op_mod_q   <= dec_fpu_p.op_mod;
            rnd_q      <= resolved_rnd;
            operands_q <= {dec_fpu_rs3_d, dec_fpu_rs2_d, dec_fpu_rs1_d};
            rd_q       <= dec_fpu_rd;
        end
    end

    // Tag bookkeeping: remember what went out, advance for the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q        <= '0;
            issued_tag_q <= '0;
        end else if (req_fire) begin
            issued_tag_q <= tag_q;
            tag_q        <= tag_q + TAG_W'(1);
        end
    end

    // Writeback registers: loaded from the matching response, then held
    // unchanged until the register file takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_fflags_q <= '0;
        end else if (wb_capture) begin
            wb_rd_q     <= rd_q;
            wb_data_q   <= fpc_rsp_result;
            wb_fflags_q <= fpc_rsp_status;
        end
    end

    // Reserved rounding mode: the op is dropped and a single-cycle
    // illegal pulse is raised the cycle after decode offered it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= dec_take && dec_reserved;
        end
    end

    assign fpu_illegal   = illegal_q;
    assign fpc_op        = op_q;
    assign fpc_op_mod    = op_mod_q;
    assign fpc_rnd       = rnd_q;
    assign fpc_operands  = operands_q;
    assign fpc_tag       = tag_q;
    assign fpu_wb_rd     = wb_rd_q;
    assign fpu_wb_data   = wb_data_q;
    assign fpu_wb_fflags = wb_fflags_q;

endmodule

// File: tb/tb_exu_fpu_ctl.sv
// -----------------------------------------------------------------------------
// tb_exu_fpu_ctl
//   Self-checking bench for exu_fpu_ctl. The bench plays decode, the FPU
//   core and the register file. Expected values come from an operation-level
//   model: resolved rounding mode, issue tag count, latency from the
//   handshake timing, and counts of writebacks and illegal pulses.
// -----------------------------------------------------------------------------
import swerv_types::*;

module tb_exu_fpu_ctl;

    localparam int TAG_W = 1;

    logic              clk;
    logic              rst;
    fpu_pkt_t          dec_fpu_p;
    logic [4:0]        dec_fpu_rd;
    logic [31:0]       dec_fpu_rs1_d;
    logic [31:0]       dec_fpu_rs2_d;
    logic [31:0]       dec_fpu_rs3_d;
    logic [2:0]        csr_frm;
    logic              flush;
    logic              fpu_busy;
    logic              fpu_illegal;
    logic              fpc_req_valid;
    logic              fpc_req_ready;
    logic [3:0]        fpc_op;
    logic              fpc_op_mod;
    logic [2:0]        fpc_rnd;
    logic [95:0]       fpc_operands;
    logic [TAG_W-1:0]  fpc_tag;
    logic              fpc_rsp_valid;
    logic              fpc_rsp_ready;
    logic [TAG_W-1:0]  fpc_rsp_tag;
    logic [31:0]       fpc_rsp_result;
    logic [4:0]        fpc_rsp_status;
    logic              fpu_wb_valid;
    logic              fpu_wb_ready;
    logic [4:0]        fpu_wb_rd;
    logic [31:0]       fpu_wb_data;
    logic [4:0]        fpu_wb_fflags;

    int                checks = 0;
    int                errors = 0;
    int                cycle = 0;
    int                wbCount = 0;
    int                illegalCount = 0;
    int                expWb = 0;
    int                expIllegal = 0;
    logic [TAG_W-1:0]  modelTag = '0;

    exu_fpu_ctl #(.TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_fpu_p      (dec_fpu_p),
        .dec_fpu_rd     (dec_fpu_rd),
        .dec_fpu_rs1_d  (dec_fpu_rs1_d),
        .dec_fpu_rs2_d  (dec_fpu_rs2_d),
        .dec_fpu_rs3_d  (dec_fpu_rs3_d),
        .csr_frm        (csr_frm),
        .flush          (flush),
        .fpu_busy       (fpu_busy),
        .fpu_illegal    (fpu_illegal),
        .fpc_req_valid  (fpc_req_valid),
        .fpc_req_ready  (fpc_req_ready),
        .fpc_op         (fpc_op),
        .fpc_op_mod     (fpc_op_mod),
        .fpc_rnd        (fpc_rnd),
        .fpc_operands   (fpc_operands),
        .fpc_tag        (fpc_tag),
        .fpc_rsp_valid  (fpc_rsp_valid),
        .fpc_rsp_ready  (fpc_rsp_ready),
        .fpc_rsp_tag    (fpc_rsp_tag),
        .fpc_rsp_result (fpc_rsp_result),
        .fpc_rsp_status (fpc_rsp_status),
        .fpu_wb_valid   (fpu_wb_valid),
        .fpu_wb_ready   (fpu_wb_ready),
        .fpu_wb_rd      (fpu_wb_rd),
        .fpu_wb_data    (fpu_wb_data),
        .fpu_wb_fflags  (fpu_wb_fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter plus writeback / illegal event counters as seen at the
    // clock edge. A flush in the writeback cycle cancels the writeback.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (!rst && fpu_wb_valid && fpu_wb_ready && !flush) wbCount <= wbCount + 1;
        if (!rst && fpu_illegal) illegalCount <= illegalCount + 1;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scrambleDecode();
        dec_fpu_rd    = 5'($urandom);
        dec_fpu_rs1_d = $urandom;
        dec_fpu_rs2_d = $urandom;
        dec_fpu_rs3_d = $urandom;
        csr_frm       = 3'($urandom);
    endtask

    // One complete operation seen from decode, core and register file.
    // flushMode: 0 none, 1 flush in REQ, 2 flush with request handshake,
    // 3 flush in WAIT, 4 flush with matching response, 5 flush with
    // wb_ready, 6 flush in WB alone.
    task automatic applyStimulus(input logic [3:0] op, input logic opMod,
                                 input logic [2:0] rndMode, input logic [2:0] frm,
                                 input logic [4:0] rd, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] rs3,
                                 input int reqDelay, input int rspDelay,
                                 input int wbDelay, input int flushMode,
                                 input bit stale, input logic [31:0] result,
                                 input logic [4:0] status);
        int               mode;
        bit               illegal;
        logic [2:0]       mode3;
        logic [127:0]     expReq;
        logic [127:0]     expWbBus;
        int               acceptEdge;
        logic [TAG_W-1:0] issued;

        mode    = (rndMode == 3'd7) ? int'(frm) : int'(rndMode);
        illegal = (mode == 5) || (mode == 6);
        mode3   = mode[2:0];

        checkOutput("idle_busy", 128'(fpu_busy), 128'(0));
        dec_fpu_p     = '{valid: 1'b1, rnd_mode: rndMode, op: op, op_mod: opMod};
        dec_fpu_rd    = rd;
        dec_fpu_rs1_d = rs1;
        dec_fpu_rs2_d = rs2;
        dec_fpu_rs3_d = rs3;
        csr_frm       = frm;
        tick();
        acceptEdge = cycle;
        dec_fpu_p  = '0;
        scrambleDecode();

        if (illegal) begin
            expIllegal++;
            checkOutput("illegal_pulse", 128'({fpu_illegal, fpc_req_valid, fpu_busy}), 128'(3'b100));
            tick();
            checkOutput("illegal_end", 128'({fpu_illegal, fpc_req_valid, fpu_busy}), 128'(3'b000));
            return;
        end

        checkOutput("no_illegal", 128'(fpu_illegal), 128'(0));
        expReq = 128'({1'b1, op, opMod, mode3, rs3, rs2, rs1, modelTag});
        checkOutput("req_payload",
                    128'({fpc_req_valid, fpc_op, fpc_op_mod, fpc_rnd, fpc_operands, fpc_tag}),
                    expReq);

        // Core holds off; decode junk must not disturb the payload.
        for (int i = 0; i < reqDelay; i++) begin
            dec_fpu_p = '{valid: 1'b1, rnd_mode: 3'($urandom), op: 4'($urandom), op_mod: 1'($urandom)};
            scrambleDecode();
            tick();
            checkOutput("req_stable",
                        128'({fpc_req_valid, fpc_op, fpc_op_mod, fpc_rnd, fpc_operands, fpc_tag}),
                        expReq);
        end
        dec_fpu_p = '0;

        if (flushMode == 1) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            checkOutput("flush_req", 128'({fpu_busy, fpc_req_valid}), 128'(2'b00));
            return;
        end

        fpc_req_ready = 1'b1;
        if (flushMode == 2) flush = 1'b1;
        tick();
        fpc_req_ready = 1'b0;
        flush         = 1'b0;
        issued        = modelTag;
        modelTag      = modelTag + 1'b1;
        checkOutput("issued", 128'({fpu_busy, fpc_req_valid, fpc_rsp_ready}), 128'(3'b101));

        if (stale) begin
            fpc_rsp_valid  = 1'b1;
            fpc_rsp_tag    = ~issued;
            fpc_rsp_result = $urandom;
            fpc_rsp_status = 5'($urandom);
            tick();
            fpc_rsp_valid = 1'b0;
            checkOutput("stale_ignored", 128'({fpu_busy, fpc_rsp_ready, fpu_wb_valid}), 128'(3'b110));
        end

        if (flushMode == 2 || flushMode == 3) begin
            if (flushMode == 3) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                checkOutput("drain", 128'({fpu_busy, fpc_rsp_ready, fpu_wb_valid}), 128'(3'b110));
                tick();
            end else begin
                for (int i = 0; i < rspDelay; i++) tick();
            end
            fpc_rsp_valid  = 1'b1;
            fpc_rsp_tag    = issued;
            fpc_rsp_result = result;
            fpc_rsp_status = status;
            tick();
            fpc_rsp_valid = 1'b0;
            checkOutput("drained", 128'({fpu_busy, fpc_rsp_ready, fpu_wb_valid}), 128'(3'b000));
            return;
        end

        for (int i = 0; i < rspDelay; i++) begin
            tick();
            checkOutput("wait", 128'({fpu_busy, fpc_rsp_ready, fpu_wb_valid}), 128'(3'b110));
        end

        fpc_rsp_valid  = 1'b1;
        fpc_rsp_tag    = issued;
        fpc_rsp_result = result;
        fpc_rsp_status = status;
        if (flushMode == 4) flush = 1'b1;
        tick();
        fpc_rsp_valid  = 1'b0;
        flush          = 1'b0;
        fpc_rsp_result = $urandom;
        fpc_rsp_status = 5'($urandom);

        if (flushMode == 4) begin
            checkOutput("flush_rsp", 128'({fpu_busy, fpc_rsp_ready, fpu_wb_valid}), 128'(3'b000));
            return;
        end

        checkOutput("wb_latency", 128'(cycle - acceptEdge + 1),
                    128'(reqDelay + rspDelay + 3 + int'(stale)));
        expWbBus = 128'({1'b1, 1'b0, rd, result, status});
        checkOutput("wb_data",
                    128'({fpu_wb_valid, fpc_rsp_ready, fpu_wb_rd, fpu_wb_data, fpu_wb_fflags}),
                    expWbBus);
        for (int i = 0; i < wbDelay; i++) begin
            tick();
            checkOutput("wb_stable",
                        128'({fpu_wb_valid, fpc_rsp_ready, fpu_wb_rd, fpu_wb_data, fpu_wb_fflags}),
                        expWbBus);
        end

        if (flushMode == 5 || flushMode == 6) begin
            flush        = 1'b1;
            fpu_wb_ready = (flushMode == 5);
            tick();
            flush        = 1'b0;
            fpu_wb_ready = 1'b0;
            checkOutput("flush_wb", 128'({fpu_busy, fpu_wb_valid}), 128'(2'b00));
            return;
        end

        fpu_wb_ready = 1'b1;
        tick();
        fpu_wb_ready = 1'b0;
        expWb++;
        checkOutput("wb_done", 128'({fpu_busy, fpu_wb_valid}), 128'(2'b00));
    endtask

    initial begin
        int fm;

        rst            = 1'b1;
        dec_fpu_p      = '0;
        dec_fpu_rd     = '0;
        dec_fpu_rs1_d  = '0;
        dec_fpu_rs2_d  = '0;
        dec_fpu_rs3_d  = '0;
        csr_frm        = '0;
        flush          = 1'b0;
        fpc_req_ready  = 1'b0;
        fpc_rsp_valid  = 1'b0;
        fpc_rsp_tag    = '0;
        fpc_rsp_result = '0;
        fpc_rsp_status = '0;
        fpu_wb_ready   = 1'b0;

        tick();
        tick();
        checkOutput("reset_ctl",
                    128'({fpu_busy, fpu_illegal, fpc_req_valid, fpc_rsp_ready, fpu_wb_valid, fpc_tag}),
                    128'(0));
        checkOutput("reset_data",
                    128'({fpc_op, fpc_op_mod, fpc_rnd, fpc_operands, fpu_wb_rd, fpu_wb_data, fpu_wb_fflags}),
                    128'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("[TB] basic op, static rounding");
        applyStimulus(4'h2, 1'b0, 3'b000, 3'b000, 5'd5, 32'h3F800000, 32'h0, 32'h0,
                      0, 3, 0, 0, 1'b0, 32'h40000000, 5'h01);

        $display("[TB] dynamic rounding");
        applyStimulus(4'h1, 1'b1, 3'b111, 3'b010, 5'd7, 32'h1, 32'h2, 32'h3,
                      0, 1, 0, 0, 1'b0, 32'h12345678, 5'h00);

        $display("[TB] reserved rounding modes");
        applyStimulus(4'h3, 1'b0, 3'b111, 3'b101, 5'd1, 32'h1, 32'h2, 32'h3,
                      0, 0, 0, 0, 1'b0, 32'h0, 5'h0);
        applyStimulus(4'h3, 1'b0, 3'b110, 3'b000, 5'd1, 32'h1, 32'h2, 32'h3,
                      0, 0, 0, 0, 1'b0, 32'h0, 5'h0);

        $display("[TB] backpressure");
        applyStimulus(4'h5, 1'b1, 3'b001, 3'b000, 5'd9, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADF00D,
                      4, 2, 3, 0, 1'b0, 32'hA5A5A5A5, 5'h1F);

        $display("[TB] flush in WAIT, then a normal op");
        applyStimulus(4'h6, 1'b0, 3'b011, 3'b000, 5'd3, 32'h11, 32'h22, 32'h33,
                      0, 0, 0, 3, 1'b0, 32'h55555555, 5'h02);
        applyStimulus(4'h7, 1'b0, 3'b100, 3'b000, 5'd4, 32'h44, 32'h55, 32'h66,
                      0, 2, 0, 0, 1'b0, 32'h66666666, 5'h04);

        $display("[TB] stale tag, then flush with wb_ready");
        applyStimulus(4'h8, 1'b1, 3'b000, 3'b000, 5'd10, 32'h77, 32'h88, 32'h99,
                      1, 1, 1, 5, 1'b1, 32'h77777777, 5'h08);

        $display("[TB] valid with flush in IDLE is dropped");
        dec_fpu_p = '{valid: 1'b1, rnd_mode: 3'b000, op: 4'h1, op_mod: 1'b0};
        flush     = 1'b1;
        tick();
        dec_fpu_p = '0;
        flush     = 1'b0;
        checkOutput("flush_idle", 128'({fpu_busy, fpu_illegal, fpc_req_valid}), 128'(3'b000));

        $display("[TB] randomized operations");
        for (int n = 0; n < 60; n++) begin
            fm = $urandom_range(0, 10);
            if (fm > 6) fm = 0;
            applyStimulus(4'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                          5'($urandom), $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          fm, ($urandom_range(0, 3) == 0), $urandom, 5'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] reset while an op is outstanding");
        dec_fpu_p     = '{valid: 1'b1, rnd_mode: 3'b000, op: 4'h4, op_mod: 1'b0};
        tick();
        dec_fpu_p     = '0;
        fpc_req_ready = 1'b1;
        tick();
        fpc_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_mid",
                    128'({fpu_busy, fpc_req_valid, fpc_rsp_ready, fpu_wb_valid, fpc_tag}),
                    128'(0));
        @(negedge clk);
        rst      = 1'b0;
        modelTag = '0;
        tick();
        applyStimulus(4'h9, 1'b0, 3'b010, 3'b000, 5'd12, 32'h100, 32'h200, 32'h300,
                      1, 1, 0, 0, 1'b0, 32'hFEEDFACE, 5'h10);

        tick();
        checkOutput("wb_count", 128'(wbCount), 128'(expWb));
        checkOutput("illegal_count", 128'(illegalCount), 128'(expIllegal));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
